scr1_accel_sched: RTL and testbench

- Job sequencer that drives the memory-mapped multiply accelerator through its dmem-style slave port, so software or a DMA can hand over operand pairs without polling.
- Accepts (A, B) jobs on a valid/ready stream and buffers them in a small FIFO.
- Per job, issues WR A, WR B, WR CTRL (go), polls CTRL until done, reads C, then returns the result on a valid/ready stream.
- Sits between a requester and the accelerator, as sole master of the accelerator port.

---
 rtl/scr1_accel_sched_pkg.sv | 44 ++++
 rtl/scr1_accel_sched_fifo.sv | 64 ++++++
 rtl/scr1_accel_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_scr1_accel_sched.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scr1_accel_sched_pkg.sv
// ---------------------------------------------------------------------------
// scr1_accel_sched_pkg
// Shared types and constants for the multiply-accelerator job sequencer:
//   - dmem-style slave port command / width / response encodings
//   - sequencer FSM state encoding
//   - accelerator register offsets and the CTRL done bit position
// ---------------------------------------------------------------------------
package scr1_accel_sched_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [2:0] {
    SCR1_ACCEL_FSM_IDLE,
    SCR1_ACCEL_FSM_WR_A,
    SCR1_ACCEL_FSM_WR_B,
    SCR1_ACCEL_FSM_WR_GO,
    SCR1_ACCEL_FSM_POLL,
    SCR1_ACCEL_FSM_RD_C,
    SCR1_ACCEL_FSM_DONE
  } type_scr1_accel_sched_fsm_e;

  localparam logic [31:0] SCR1_ACCEL_OFS_CTRL = 32'h0000_0000;
  localparam logic [31:0] SCR1_ACCEL_OFS_A    = 32'h0000_0008;
  localparam logic [31:0] SCR1_ACCEL_OFS_B    = 32'h0000_000C;
  localparam logic [31:0] SCR1_ACCEL_OFS_C    = 32'h0000_0010;

  localparam int SCR1_ACCEL_DONE_BIT = 31;

endpackage : scr1_accel_sched_pkg

// File: rtl/scr1_accel_sched_fifo.sv
// ---------------------------------------------------------------------------
// scr1_accel_sched_fifo
// Synchronous job FIFO holding {a, b} operand pairs (64-bit entries).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers only)
//   push, push_data   write request; ignored while full
//   pop, pop_data     read request; pop_data shows the head combinationally
//   full, empty       occupancy flags
// Pointers carry one extra wrap bit so full/empty are told apart without a
// separate counter.
// ---------------------------------------------------------------------------
module scr1_accel_sched_fifo #(
  parameter int JOB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [63:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(JOB_DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [63:0]  mem_q [JOB_DEPTH];
  logic         push_en;
  logic         pop_en;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_en)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage has no reset; empty/full are derived from the pointers only.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule : scr1_accel_sched_fifo

// File: rtl/scr1_accel_sched.sv
// ---------------------------------------------------------------------------
// scr1_accel_sched
// Job sequencer that drives the memory-mapped multiply accelerator. Jobs
// (A, B) are queued in a FIFO; per job it writes A, B, CTRL (go), polls CTRL
// until bit31 (done) is set, reads C and returns it on the result stream.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   job_vld/job_rdy/job_a/job_b        job input stream
//   res_vld/res_rdy/res_data/res_err   result output stream
//   busy, jobs_done                    status
//   acc_*                              master side of accelerator dmem port
// Optional build macro:
//   SCR1_ACCEL_SCHED_TIMEOUT_EN        bound POLL to POLL_MAX not-done reads,
//                                      then abort the job with res_err=1
// ---------------------------------------------------------------------------
module scr1_accel_sched
  import scr1_accel_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          JOB_DEPTH = 2,
  parameter int          POLL_MAX  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 job_vld,
  output logic                 job_rdy,
  input  logic [31:0]          job_a,
  input  logic [31:0]          job_b,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [31:0]          res_data,
  output logic                 res_err,
  output logic                 busy,
  output logic [15:0]          jobs_done,
  output logic                 acc_req,
  input  logic                 acc_req_ack,
  output type_scr1_mem_cmd_e   acc_cmd,
  output type_scr1_mem_width_e acc_width,
  output logic [31:0]          acc_addr,
  output logic [31:0]          acc_wdata,
  input  logic [31:0]          acc_rdata,
  input  type_scr1_mem_resp_e  acc_resp
);

  // Elaboration-time parameter sanity checks.
  if (JOB_DEPTH < 2 || (JOB_DEPTH & (JOB_DEPTH - 1)) != 0) begin : g_bad_job_depth
    $error("scr1_accel_sched: JOB_DEPTH must be a power of 2 and at least 2");
  end
  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("scr1_accel_sched: POLL_MAX must be at least 1");
  end

  type_scr1_accel_sched_fsm_e state_q, state_d;
  logic               acc_req_q,   acc_req_d;
  type_scr1_mem_cmd_e acc_cmd_q,   acc_cmd_d;
  logic [31:0]        acc_addr_q,  acc_addr_d;
  logic [31:0]        acc_wdata_q, acc_wdata_d;
  logic [31:0]        op_b_q,      op_b_d;
  logic [31:0]        res_data_q,  res_data_d;
  logic               res_err_q,   res_err_d;
  logic               res_vld_q,   res_vld_d;
  logic [15:0]        jobs_done_q, jobs_done_d;
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
  localparam logic [16:0] POLL_LIMIT = 17'(POLL_MAX);
  logic [15:0]        poll_cnt_q,  poll_cnt_d;
`endif

  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [63:0] fifo_head;

  scr1_accel_sched_fifo #(
    .JOB_DEPTH (JOB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (job_vld),
    .push_data ({job_a, job_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign job_rdy   = !fifo_full;
  assign busy      = (state_q != SCR1_ACCEL_FSM_IDLE) || !fifo_empty;
  assign res_vld   = res_vld_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign jobs_done = jobs_done_q;
  assign acc_req   = acc_req_q;
  assign acc_cmd   = acc_cmd_q;
  assign acc_width = SCR1_MEM_WIDTH_WORD;
  assign acc_addr  = acc_addr_q;
  assign acc_wdata = acc_wdata_q;

  // In a memory state, acc_req_q=1 is the REQ phase and acc_req_q=0 the WAIT
  // phase, so responses are only looked at after the request was acked.
  always_comb begin
    state_d     = state_q;
    acc_req_d   = acc_req_q;
    acc_cmd_d   = acc_cmd_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    op_b_d      = op_b_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_vld_d   = res_vld_q;
    jobs_done_d = jobs_done_q;
    fifo_pop    = 1'b0;
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
    poll_cnt_d  = poll_cnt_q;
`endif

    case (state_q)
      SCR1_ACCEL_FSM_IDLE: begin
        if (!fifo_empty) begin
          // A goes straight into the write-data register, which holds it
          // through WR_A; B is parked until WR_B.
          fifo_pop    = 1'b1;
          op_b_d      = fifo_head[31:0];
          state_d     = SCR1_ACCEL_FSM_WR_A;
          acc_req_d   = 1'b1;
          acc_cmd_d   = SCR1_MEM_CMD_WR;
          acc_addr_d  = BASE_ADDR + SCR1_ACCEL_OFS_A;
          acc_wdata_d = fifo_head[63:32];
        end
      end

      SCR1_ACCEL_FSM_DONE: begin
        if (res_rdy) begin
          res_vld_d   = 1'b0;
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = SCR1_ACCEL_FSM_IDLE;
        end
      end

      default: begin
        if (acc_req_q) begin
          if (acc_req_ack) acc_req_d = 1'b0;
        end else if (acc_resp == SCR1_MEM_RESP_RDY_ER) begin
          res_data_d = 32'd0;
          res_err_d  = 1'b1;
          res_vld_d  = 1'b1;
          state_d    = SCR1_ACCEL_FSM_DONE;
        end else if (acc_resp == SCR1_MEM_RESP_RDY_OK) begin
          case (state_q)
            SCR1_ACCEL_FSM_WR_A: begin
              state_d     = SCR1_ACCEL_FSM_WR_B;
              acc_req_d   = 1'b1;
              acc_addr_d  = BASE_ADDR + SCR1_ACCEL_OFS_B;
              acc_wdata_d = op_b_q;
            end
            SCR1_ACCEL_FSM_WR_B: begin
              state_d     = SCR1_ACCEL_FSM_WR_GO;
              acc_req_d   = 1'b1;
              acc_addr_d  = BASE_ADDR + SCR1_ACCEL_OFS_CTRL;
              acc_wdata_d = 32'd1;
            end
            SCR1_ACCEL_FSM_WR_GO: begin
              state_d     = SCR1_ACCEL_FSM_POLL;
              acc_req_d   = 1'b1;
              acc_cmd_d   = SCR1_MEM_CMD_RD;
              acc_addr_d  = BASE_ADDR + SCR1_ACCEL_OFS_CTRL;
              acc_wdata_d = 32'd0;
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
              poll_cnt_d  = 16'd0;
`endif
            end
            SCR1_ACCEL_FSM_POLL: begin
              if (acc_rdata[SCR1_ACCEL_DONE_BIT]) begin
                state_d    = SCR1_ACCEL_FSM_RD_C;
                acc_req_d  = 1'b1;
                acc_addr_d = BASE_ADDR + SCR1_ACCEL_OFS_C;
              end else begin
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
                if (({1'b0, poll_cnt_q} + 17'd1) >= POLL_LIMIT) begin
                  res_data_d = 32'd0;
                  res_err_d  = 1'b1;
                  res_vld_d  = 1'b1;
                  state_d    = SCR1_ACCEL_FSM_DONE;
                end else begin
                  poll_cnt_d = poll_cnt_q + 16'd1;
                  acc_req_d  = 1'b1;
                end
`else
                acc_req_d = 1'b1;
`endif
              end
            end
            SCR1_ACCEL_FSM_RD_C: begin
              res_data_d = acc_rdata;
              res_err_d  = 1'b0;
              res_vld_d  = 1'b1;
              state_d    = SCR1_ACCEL_FSM_DONE;
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCR1_ACCEL_FSM_IDLE;
      acc_req_q   <= 1'b0;
      acc_cmd_q   <= SCR1_MEM_CMD_RD;
      acc_addr_q  <= BASE_ADDR;
      acc_wdata_q <= 32'd0;
      op_b_q      <= 32'd0;
      res_data_q  <= 32'd0;
      res_err_q   <= 1'b0;
      res_vld_q   <= 1'b0;
      jobs_done_q <= 16'd0;
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
      poll_cnt_q  <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      acc_req_q   <= acc_req_d;
      acc_cmd_q   <= acc_cmd_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      op_b_q      <= op_b_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_vld_q   <= res_vld_d;
      jobs_done_q <= jobs_done_d;
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

endmodule : scr1_accel_sched

// File: tb/tb_scr1_accel_sched.sv
// ---------------------------------------------------------------------------
// tb_scr1_accel_sched
// Directed bench for scr1_accel_sched with a behavioural accelerator model
// (A/B/CTRL/C registers, done set a fixed number of cycles after go,
// optional ack stalls, error injection on one address, never-done mode).
// Honours SCR1_ACCEL_SCHED_TIMEOUT_EN to pick the timeout or reset scenario.
// ---------------------------------------------------------------------------
module tb_scr1_accel_sched;
  import scr1_accel_sched_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          LOGN = 1024;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 job_vld = 1'b0;
  logic                 job_rdy;
  logic [31:0]          job_a = 32'd0;
  logic [31:0]          job_b = 32'd0;
  logic                 res_vld;
  logic                 res_rdy = 1'b0;
  logic [31:0]          res_data;
  logic                 res_err;
  logic                 busy;
  logic [15:0]          jobs_done;
  logic                 acc_req;
  logic                 acc_req_ack;
  type_scr1_mem_cmd_e   acc_cmd;
  type_scr1_mem_width_e acc_width;
  logic [31:0]          acc_addr;
  logic [31:0]          acc_wdata;
  logic [31:0]          acc_rdata;
  type_scr1_mem_resp_e  acc_resp;

  int tests_run = 0;
  int tests_failed = 0;

  // Model controls, written only by the stimulus process.
  int          stall_cycles = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'd0;
  logic        never_done = 1'b0;

  // Model state, written only by the model process.
  logic [31:0] m_a, m_b;
  int          done_cnt;
  logic        running;
  int          stall_cnt;
  logic [64:0] bus_log [LOGN];
  int          log_n = 0;
  logic        m_done;

  scr1_accel_sched #(
    .BASE_ADDR (BASE),
    .JOB_DEPTH (2),
    .POLL_MAX  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .job_vld     (job_vld),
    .job_rdy     (job_rdy),
    .job_a       (job_a),
    .job_b       (job_b),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .res_data    (res_data),
    .res_err     (res_err),
    .busy        (busy),
    .jobs_done   (jobs_done),
    .acc_req     (acc_req),
    .acc_req_ack (acc_req_ack),
    .acc_cmd     (acc_cmd),
    .acc_width   (acc_width),
    .acc_addr    (acc_addr),
    .acc_wdata   (acc_wdata),
    .acc_rdata   (acc_rdata),
    .acc_resp    (acc_resp)
  );

  always #5 clk = ~clk;

  assign m_done      = running && (done_cnt == 0) && !never_done;
  assign acc_req_ack = acc_req && (stall_cnt >= stall_cycles);

  // Accelerator model: ack combinational, response one cycle after ack.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_resp  <= SCR1_MEM_RESP_NOTRDY;
      acc_rdata <= 32'd0;
      m_a       <= 32'd0;
      m_b       <= 32'd0;
      done_cnt  <= 0;
      running   <= 1'b0;
      stall_cnt <= 0;
    end else begin
      if (done_cnt > 0) done_cnt <= done_cnt - 1;
      if (acc_req && !acc_req_ack) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      acc_resp  <= SCR1_MEM_RESP_NOTRDY;
      acc_rdata <= 32'd0;
      if (acc_req && acc_req_ack) begin
        bus_log[log_n % LOGN] <= {acc_cmd == SCR1_MEM_CMD_WR, acc_addr, acc_wdata};
        log_n <= log_n + 1;
        if (err_en && acc_addr == err_addr) begin
          acc_resp <= SCR1_MEM_RESP_RDY_ER;
        end else begin
          acc_resp <= SCR1_MEM_RESP_RDY_OK;
          if (acc_cmd == SCR1_MEM_CMD_WR) begin
            if (acc_addr == BASE + 32'h08) m_a <= acc_wdata;
            if (acc_addr == BASE + 32'h0C) m_b <= acc_wdata;
            if (acc_addr == BASE) begin
              running  <= 1'b1;
              done_cnt <= 3;
            end
          end else begin
            if (acc_addr == BASE) acc_rdata <= {m_done, 31'd0};
            if (acc_addr == BASE + 32'h10) acc_rdata <= m_a * m_b;
          end
        end
      end
    end
  end

  task automatic push_job(input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    job_vld = 1'b1;
    job_a = a;
    job_b = b;
    for (int i = 0; i < 200; i++) begin
      if (job_rdy) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    job_vld = 1'b0;
  endtask

  task automatic wait_result(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (res_vld) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    res_rdy = 1'b1;
    @(negedge clk);
    res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({job_rdy, res_vld, res_err, busy, acc_req} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/vld/err/busy/req=%b want 10000",
               {job_rdy, res_vld, res_err, busy, acc_req});
    end
    tests_run++;
    if (res_data !== 32'd0 || jobs_done !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_data: got res_data=%h jobs_done=%0d want 0/0", res_data, jobs_done);
    end
    tests_run++;
    if (acc_cmd !== SCR1_MEM_CMD_RD || acc_addr !== BASE || acc_wdata !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: got cmd=%0d addr=%h wdata=%h want 0/%h/0",
               acc_cmd, acc_addr, acc_wdata, BASE);
    end
    tests_run++;
    if (acc_width !== SCR1_MEM_WIDTH_WORD) begin
      tests_failed++;
      $display("FAIL reset_width: got %0d want %0d", acc_width, SCR1_MEM_WIDTH_WORD);
    end
  endtask

  task automatic test_single_job();
    bit ok;
    int base;
    logic [64:0] e;
    base = log_n;
    push_job(32'd5, 32'd7, ok);
    wait_result(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL single_timeout: got no res_vld want res_vld within 500 cycles");
    end
    $display("[TB] job A=%h B=%h -> res=%h err=%b", 32'd5, 32'd7, res_data, res_err);
    tests_run++;
    if (res_data !== 32'h23 || res_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_result: got %h err=%b want 00000023 err=0", res_data, res_err);
    end
    tests_run++;
    if (log_n - base < 5) begin
      tests_failed++;
      $display("FAIL single_bus_count: got %0d transactions want >=5", log_n - base);
    end
    e = bus_log[base % LOGN];
    tests_run++;
    if (e !== {1'b1, BASE + 32'h08, 32'd5}) begin
      tests_failed++;
      $display("FAIL single_wr_a: got %h want %h", e, {1'b1, BASE + 32'h08, 32'd5});
    end
    e = bus_log[(base + 1) % LOGN];
    tests_run++;
    if (e !== {1'b1, BASE + 32'h0C, 32'd7}) begin
      tests_failed++;
      $display("FAIL single_wr_b: got %h want %h", e, {1'b1, BASE + 32'h0C, 32'd7});
    end
    e = bus_log[(base + 2) % LOGN];
    tests_run++;
    if (e[64:32] !== {1'b1, BASE}) begin
      tests_failed++;
      $display("FAIL single_wr_go: got %h want %h", e[64:32], {1'b1, BASE});
    end
    e = bus_log[(base + 3) % LOGN];
    tests_run++;
    if (e[64:32] !== {1'b0, BASE}) begin
      tests_failed++;
      $display("FAIL single_poll: got %h want %h", e[64:32], {1'b0, BASE});
    end
    e = bus_log[(log_n - 1) % LOGN];
    tests_run++;
    if (e[64:32] !== {1'b0, BASE + 32'h10}) begin
      tests_failed++;
      $display("FAIL single_rd_c: got %h want %h", e[64:32], {1'b0, BASE + 32'h10});
    end
    handshake();
    tests_run++;
    if (jobs_done !== 16'd1 || res_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: got jobs_done=%0d res_vld=%b want 1/0", jobs_done, res_vld);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] jd0;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] exp_c [3];
    av = '{32'd5, 32'd3, 32'd1};
    bv = '{32'd7, 32'd4, 32'd1};
    exp_c = '{32'h23, 32'h0C, 32'h01};
    jd0 = jobs_done;
    for (int j = 0; j < 3; j++) begin
      push_job(av[j], bv[j], ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL b2b_push%0d: got not accepted want accepted", j);
      end
    end
    tests_run++;
    if (job_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_full: got job_rdy=%b want 0", job_rdy);
    end
    for (int j = 0; j < 3; j++) begin
      wait_result(ok);
      $display("[TB] job A=%h B=%h -> res=%h err=%b", av[j], bv[j], res_data, res_err);
      tests_run++;
      if (!ok || res_data !== exp_c[j] || res_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_result%0d: got vld=%b %h err=%b want 1 %h 0",
                 j, ok, res_data, res_err, exp_c[j]);
      end
      handshake();
      tests_run++;
      if (busy !== (j < 2)) begin
        tests_failed++;
        $display("FAIL b2b_busy%0d: got %b want %b", j, busy, j < 2);
      end
    end
    tests_run++;
    if (jobs_done !== jd0 + 16'd3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want %0d", jobs_done, jd0 + 16'd3);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    bit noreq;
    logic [31:0] d;
    logic e;
    push_job(32'd2, 32'd3, ok);
    push_job(32'd4, 32'd5, ok);
    wait_result(ok);
    d = res_data;
    e = res_err;
    stable = 1'b1;
    noreq = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (res_vld !== 1'b1 || res_data !== d || res_err !== e) stable = 1'b0;
      if (acc_req !== 1'b0) noreq = 1'b0;
      @(negedge clk);
    end
    $display("[TB] job A=%h B=%h -> res=%h err=%b (held 20 cycles)", 32'd2, 32'd3, d, e);
    tests_run++;
    if (!ok || d !== 32'd6 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_result: got vld=%b %h err=%b want 1 00000006 0", ok, d, e);
    end
    tests_run++;
    if (!stable || !noreq) begin
      tests_failed++;
      $display("FAIL bp_hold: got stable=%b no_req=%b want 1/1", stable, noreq);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_busy: got %b want 1", busy);
    end
    handshake();
    wait_result(ok);
    $display("[TB] job A=%h B=%h -> res=%h err=%b", 32'd4, 32'd5, res_data, res_err);
    tests_run++;
    if (!ok || res_data !== 32'h14 || res_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_pending: got vld=%b %h err=%b want 1 00000014 0", ok, res_data, res_err);
    end
    handshake();
  endtask

  task automatic test_ack_stall();
    bit ok;
    bit held;
    stall_cycles = 5;
    push_job(32'd9, 32'd2, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    held = ok;
    for (int k = 0; k < 5; k++) begin
      if (acc_req !== 1'b1 || acc_cmd !== SCR1_MEM_CMD_WR ||
          acc_addr !== BASE + 32'h08 || acc_wdata !== 32'd9) held = 1'b0;
      @(negedge clk);
    end
    tests_run++;
    if (!held) begin
      tests_failed++;
      $display("FAIL stall_hold: got req=%b addr=%h wdata=%h (held=%b) want 1/%h/00000009 held",
               acc_req, acc_addr, acc_wdata, held, BASE + 32'h08);
    end
    stall_cycles = 0;
    wait_result(ok);
    $display("[TB] job A=%h B=%h -> res=%h err=%b (ack stall)", 32'd9, 32'd2, res_data, res_err);
    tests_run++;
    if (!ok || res_data !== 32'h12 || res_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_result: got vld=%b %h err=%b want 1 00000012 0", ok, res_data, res_err);
    end
    handshake();
  endtask

  task automatic test_error();
    bit ok;
    int base;
    logic [15:0] jd0;
    logic [64:0] e;
    jd0 = jobs_done;
    base = log_n;
    err_en = 1'b1;
    err_addr = BASE + 32'h0C;
    push_job(32'd1, 32'd2, ok);
    wait_result(ok);
    $display("[TB] job A=%h B=%h -> res=%h err=%b (RDY_ER on B)", 32'd1, 32'd2, res_data, res_err);
    tests_run++;
    if (!ok || res_err !== 1'b1 || res_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL err_result: got vld=%b %h err=%b want 1 00000000 1", ok, res_data, res_err);
    end
    e = bus_log[(base + 1) % LOGN];
    tests_run++;
    if (log_n - base != 2 || e[64:32] !== {1'b1, BASE + 32'h0C}) begin
      tests_failed++;
      $display("FAIL err_no_go: got %0d transactions last=%h want 2 last=%h",
               log_n - base, e[64:32], {1'b1, BASE + 32'h0C});
    end
    err_en = 1'b0;
    handshake();
    tests_run++;
    if (jobs_done !== jd0 + 16'd1) begin
      tests_failed++;
      $display("FAIL err_count: got %0d want %0d", jobs_done, jd0 + 16'd1);
    end
  endtask

`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int base;
    int polls;
    logic [64:0] e;
    never_done = 1'b1;
    base = log_n;
    push_job(32'd3, 32'd3, ok);
    wait_result(ok);
    polls = 0;
    for (int i = base; i < log_n; i++) begin
      e = bus_log[i % LOGN];
      if (e[64:32] == {1'b0, BASE}) polls++;
    end
    $display("[TB] job A=%h B=%h -> res=%h err=%b (timeout, %0d polls)",
             32'd3, 32'd3, res_data, res_err, polls);
    tests_run++;
    if (!ok || res_err !== 1'b1 || res_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL timeout_result: got vld=%b %h err=%b want 1 00000000 1", ok, res_data, res_err);
    end
    tests_run++;
    if (polls != 4) begin
      tests_failed++;
      $display("FAIL timeout_polls: got %0d want 4", polls);
    end
    handshake();
    never_done = 1'b0;
  endtask
`else
  task automatic test_reset_mid_poll();
    bit ok;
    int base;
    int polls;
    logic [64:0] e;
    never_done = 1'b1;
    base = log_n;
    push_job(32'd3, 32'd3, ok);
    repeat (60) @(negedge clk);
    polls = 0;
    for (int i = base; i < log_n; i++) begin
      e = bus_log[i % LOGN];
      if (e[64:32] == {1'b0, BASE}) polls++;
    end
    tests_run++;
    if (polls <= 10 || res_vld !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL poll_unbounded: got polls=%0d res_vld=%b busy=%b want >10/0/1",
               polls, res_vld, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (acc_req !== 1'b0 || busy !== 1'b0 || res_vld !== 1'b0 ||
        jobs_done !== 16'd0 || job_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset: got req=%b busy=%b vld=%b done=%0d rdy=%b want 0/0/0/0/1",
               acc_req, busy, res_vld, jobs_done, job_rdy);
    end
    rst_n = 1'b1;
    never_done = 1'b0;
    @(negedge clk);
    push_job(32'd6, 32'd7, ok);
    wait_result(ok);
    $display("[TB] job A=%h B=%h -> res=%h err=%b (after reset)", 32'd6, 32'd7, res_data, res_err);
    tests_run++;
    if (!ok || res_data !== 32'h2A || res_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_job: got vld=%b %h err=%b want 1 0000002a 0", ok, res_data, res_err);
    end
    handshake();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single_job();
    test_back_to_back();
    test_backpressure();
    test_ack_stall();
    test_error();
`ifdef SCR1_ACCEL_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_reset_mid_poll();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_scr1_accel_sched
